// File: rtl/counter_m_pkg.sv
// Shared definitions for the counter_M arbiter: state encoding and default parameters.
package counter_m_pkg;

    localparam int M_DEFAULT      = 10;
    localparam int WRAP_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: combinational select, pointer flips away from each winner.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       take_i,
    output logic [1:0] gnt_o
);

    // ptr_q names the requester that wins a tie.
    logic ptr_q;

    always_comb begin
        // NOTE: default first so every path assigns gnt_o and no latch is inferred.
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else if (take_i && (req_i != 2'b00)) begin
            ptr_q <= gnt_o[0];
        end
    end

endmodule

// File: rtl/counter_m_arbiter.sv
// Shares one counter_M between two requesters: grant, clear, count N carries, pulse done.
// Optional carry watchdog with sticky err: define COUNTER_M_ARB_TIMEOUT_EN.
module counter_m_arbiter
    import counter_m_pkg::*;
#(
    parameter int M      = M_DEFAULT,
    parameter int WRAP_W = WRAP_W_DEFAULT
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [1:0]        req,
    input  logic [WRAP_W-1:0] len0,
    input  logic [WRAP_W-1:0] len1,
    output logic [1:0]        gnt,
    output logic [1:0]        done,
    output logic              busy,
    output logic              cnt_enable,
    output logic              cnt_clr_n,
    input  logic              cnt_carry,
    output logic              err
);

    state_e            state_q;
    logic [1:0]        gnt_q;
    logic [1:0]        done_q;
    logic              busy_q;
    logic              cnt_enable_q;
    logic              cnt_clr_n_q;
    logic [WRAP_W-1:0] len_q;
    logic [WRAP_W-1:0] wrap_q;

    logic [1:0]        arb_gnt;
    logic              arb_take;
    logic              req_held;
    logic              last_wrap;
    logic              timeout;
    logic [WRAP_W-1:0] len_sel;

    assign arb_take  = (state_q == IDLE) && (req != 2'b00);
    assign req_held  = |(req & gnt_q);
    assign last_wrap = (wrap_q == (len_q - WRAP_W'(1)));
    assign len_sel   = arb_gnt[1] ? len1 : len0;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (Reset),
        .req_i  (req),
        .take_i (arb_take),
        .gnt_o  (arb_gnt)
    );

`ifdef COUNTER_M_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(M + 3);

    logic [WD_W-1:0] wd_q;
    logic            err_q;

    // Trips on the RUN cycle that would carry the watchdog to M+2 without a carry.
    assign timeout = (state_q == RUN) && !cnt_carry && (wd_q == WD_W'(M + 1));

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if ((state_q != RUN) || cnt_carry) begin
                wd_q <= '0;
            end else begin
                wd_q <= wd_q + WD_W'(1);
            end
            if (timeout && req_held) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    // Without the watchdog err stays low for every legal modulus.
    assign err     = (M < 1);
`endif

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= IDLE;
            gnt_q        <= 2'b00;
            done_q       <= 2'b00;
            busy_q       <= 1'b0;
            cnt_enable_q <= 1'b0;
            cnt_clr_n_q  <= 1'b1;
            len_q        <= '0;
            wrap_q       <= '0;
        end else begin
            // NOTE: non-blocking throughout, so every branch sees the pre-edge register values.
            done_q <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (req != 2'b00) begin
                        gnt_q       <= arb_gnt;
                        len_q       <= len_sel;
                        busy_q      <= 1'b1;
                        cnt_clr_n_q <= 1'b0;
                        state_q     <= CLEAR;
                    end
                end
                CLEAR: begin
                    cnt_clr_n_q <= 1'b1;
                    wrap_q      <= '0;
                    if (len_q == '0) begin
                        done_q  <= gnt_q;
                        state_q <= DONE;
                    end else begin
                        cnt_enable_q <= 1'b1;
                        state_q      <= RUN;
                    end
                end
                RUN: begin
                    if (!req_held || timeout) begin
                        // Requester withdrew or the counter stalled: abandon without done.
                        gnt_q        <= 2'b00;
                        busy_q       <= 1'b0;
                        cnt_enable_q <= 1'b0;
                        state_q      <= IDLE;
                    end else if (cnt_carry) begin
                        wrap_q <= wrap_q + WRAP_W'(1);
                        if (last_wrap) begin
                            cnt_enable_q <= 1'b0;
                            done_q       <= gnt_q;
                            state_q      <= DONE;
                        end
                    end
                end
                DONE: begin
                    gnt_q   <= 2'b00;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    gnt_q        <= 2'b00;
                    busy_q       <= 1'b0;
                    cnt_enable_q <= 1'b0;
                    cnt_clr_n_q  <= 1'b1;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign gnt        = gnt_q;
    assign done       = done_q;
    assign busy       = busy_q;
    assign cnt_enable = cnt_enable_q;
    assign cnt_clr_n  = cnt_clr_n_q;

endmodule

// File: tb/tb_counter_m_arbiter.sv
// Directed bench for counter_m_arbiter with a behavioural counter_M (M=10) driving cnt_carry.
// A scoreboard queue holds expected gnt changes and done pulses; a forked monitor pops them.
module tb_counter_m_arbiter;

    localparam int M      = 10;
    localparam int WRAP_W = 8;

    logic              clk    = 1'b0;
    logic              Reset  = 1'b0;
    logic [1:0]        req    = 2'b00;
    logic [WRAP_W-1:0] len0   = '0;
    logic [WRAP_W-1:0] len1   = '0;
    logic [1:0]        gnt;
    logic [1:0]        done;
    logic              busy;
    logic              cnt_enable;
    logic              cnt_clr_n;
    logic              cnt_carry;
    logic              err;

    logic block_carry = 1'b0;
    int   cnt_m;
    int   n_checks = 0;
    int   n_fail   = 0;

    typedef struct {
        bit         is_done;
        logic [1:0] val;
    } ev_t;

    ev_t sb_q[$];

    counter_m_arbiter #(.M(M), .WRAP_W(WRAP_W)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .req        (req),
        .len0       (len0),
        .len1       (len1),
        .gnt        (gnt),
        .done       (done),
        .busy       (busy),
        .cnt_enable (cnt_enable),
        .cnt_clr_n  (cnt_clr_n),
        .cnt_carry  (cnt_carry),
        .err        (err)
    );

    always #5 clk = ~clk;

    // counter_M: modulo-M, synchronous clear, carry while enabled at terminal count.
    always @(posedge clk or negedge Reset) begin
        if (!Reset)                cnt_m <= 0;
        else if (!cnt_clr_n)       cnt_m <= 0;
        else if (cnt_enable)       cnt_m <= (cnt_m == M - 1) ? 0 : cnt_m + 1;
    end
    assign cnt_carry = cnt_enable && (cnt_m == M - 1) && !block_carry;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input bit is_done, input logic [1:0] val);
        ev_t e;
        e.is_done = is_done;
        e.val     = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_compare(input bit is_done, input logic [1:0] val);
        ev_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: %s=%b seen, nothing expected", is_done ? "done" : "gnt", val);
            return;
        end
        e = sb_q.pop_front();
        check(is_done ? "sb_done_event" : "sb_gnt_event", 32'({is_done, val}), 32'({e.is_done, e.val}));
    endtask

    task automatic monitor();
        logic [1:0] gnt_prev = 2'b00;
        forever begin
            @(negedge clk);
            if (done != 2'b00) sb_compare(1'b1, done);
            if (gnt != gnt_prev) sb_compare(1'b0, gnt);
            gnt_prev = gnt;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},   32'(gnt),        0);
        check({tag, "_done"},  32'(done),       0);
        check({tag, "_busy"},  32'(busy),       0);
        check({tag, "_en"},    32'(cnt_enable), 0);
        check({tag, "_clr_n"}, 32'(cnt_clr_n),  1);
        check({tag, "_err"},   32'(err),        0);
    endtask

    task automatic apply_reset();
        req   = 2'b00;
        Reset = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        Reset = 1'b1;
    endtask

    // Waits for a done pulse, counting enabled cycles, carries and last-carry-to-done distance.
    task automatic run_until_done(input string name, input int budget,
                                  output int en_cyc, output int carries, output int lat);
        int last_carry;
        last_carry = -1;
        en_cyc     = 0;
        carries    = 0;
        lat        = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done != 2'b00) begin
                lat = i - last_carry;
                return;
            end
            if (cnt_enable) en_cyc++;
            if (cnt_carry) begin
                carries++;
                last_carry = i;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s: no done pulse within %0d cycles", name, budget);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        int en_cyc;
        int carries;
        int lat;

        fork
            monitor();
        join_none

        // Single request, len0=3: 30 enabled cycles, done one cycle after the 3rd carry.
        apply_reset();
        expect_ev(1'b0, 2'b01);
        expect_ev(1'b1, 2'b01);
        expect_ev(1'b0, 2'b00);
        len0 = 8'd3;
        req  = 2'b01;
        @(negedge clk);
        check("single_gnt",   32'(gnt),        32'b01);
        check("single_clr_n", 32'(cnt_clr_n),  0);
        check("single_en0",   32'(cnt_enable), 0);
        check("single_busy",  32'(busy),       1);
        run_until_done("single", 200, en_cyc, carries, lat);
        check("single_en_cycles", en_cyc,  30);
        check("single_carries",   carries, 3);
        check("single_latency",   lat,     1);
        check("single_done",      32'(done), 32'b01);
        req = 2'b00;
        @(negedge clk);
        check("single_idle_busy", 32'(busy), 0);
        check("single_idle_done", 32'(done), 0);
        check("single_idle_gnt",  32'(gnt),  0);

        // Contention from reset: 0, then 1 after one IDLE cycle, then 0 again.
        apply_reset();
        expect_ev(1'b0, 2'b01);
        expect_ev(1'b1, 2'b01);
        expect_ev(1'b0, 2'b00);
        expect_ev(1'b0, 2'b10);
        expect_ev(1'b1, 2'b10);
        expect_ev(1'b0, 2'b00);
        expect_ev(1'b0, 2'b01);
        expect_ev(1'b0, 2'b00);
        len0 = 8'd1;
        len1 = 8'd2;
        req  = 2'b11;
        @(negedge clk);
        check("cont_first_gnt", 32'(gnt), 32'b01);
        run_until_done("cont_r0", 200, en_cyc, carries, lat);
        check("cont_r0_en_cycles", en_cyc, 10);
        @(negedge clk);
        check("cont_idle_gnt",  32'(gnt),  0);
        check("cont_idle_busy", 32'(busy), 0);
        @(negedge clk);
        check("cont_second_gnt", 32'(gnt), 32'b10);
        run_until_done("cont_r1", 200, en_cyc, carries, lat);
        check("cont_r1_carries", carries, 2);
        check("cont_r1_done",    32'(done), 32'b10);
        @(negedge clk);
        @(negedge clk);
        check("cont_third_gnt", 32'(gnt), 32'b01);
        req = 2'b00;
        repeat (2) @(negedge clk);
        check("cont_withdraw_gnt", 32'(gnt), 0);

        // Zero length: IDLE, CLEAR, DONE with the counter never enabled.
        apply_reset();
        expect_ev(1'b0, 2'b10);
        expect_ev(1'b1, 2'b10);
        expect_ev(1'b0, 2'b00);
        len1 = 8'd0;
        req  = 2'b10;
        @(negedge clk);
        check("zero_gnt",   32'(gnt),        32'b10);
        check("zero_clr_n", 32'(cnt_clr_n),  0);
        check("zero_en_a",  32'(cnt_enable), 0);
        @(negedge clk);
        check("zero_done",  32'(done),       32'b10);
        check("zero_en_b",  32'(cnt_enable), 0);
        req = 2'b00;
        @(negedge clk);
        check("zero_idle_busy", 32'(busy),       0);
        check("zero_en_c",      32'(cnt_enable), 0);

        // Abort: requester 0 drops after the 2nd carry of a 5-wrap run.
        apply_reset();
        expect_ev(1'b0, 2'b01);
        expect_ev(1'b0, 2'b00);
        len0    = 8'd5;
        req     = 2'b01;
        carries = 0;
        for (int i = 0; i < 200 && carries < 2; i++) begin
            @(negedge clk);
            if (cnt_carry) carries++;
        end
        check("abort_two_carries", carries, 2);
        @(negedge clk);
        req = 2'b00;
        @(negedge clk);
        check("abort_en",   32'(cnt_enable), 0);
        check("abort_gnt",  32'(gnt),        0);
        check("abort_busy", 32'(busy),       0);
        repeat (3) @(negedge clk);
        check("abort_no_done", 32'(done), 0);

        // Asynchronous reset mid-RUN, then a pending 2'b11 goes to requester 0.
        apply_reset();
        expect_ev(1'b0, 2'b01);
        expect_ev(1'b0, 2'b00);
        expect_ev(1'b0, 2'b01);
        expect_ev(1'b0, 2'b00);
        len0 = 8'd4;
        len1 = 8'd4;
        req  = 2'b11;
        repeat (5) @(negedge clk);
        check("areset_running", 32'(cnt_enable), 1);
        #2 Reset = 1'b0;
        #1 check_reset_outputs("areset");
        @(negedge clk);
        Reset = 1'b1;
        @(negedge clk);
        check("areset_regrant", 32'(gnt), 32'b01);
        req = 2'b00;
        repeat (2) @(negedge clk);
        check("areset_final_gnt", 32'(gnt), 0);

`ifdef COUNTER_M_ARB_TIMEOUT_EN
        // Stalled counter: err after 12 RUN cycles, sticky through a later run.
        apply_reset();
        expect_ev(1'b0, 2'b01);
        expect_ev(1'b0, 2'b00);
        expect_ev(1'b0, 2'b01);
        expect_ev(1'b1, 2'b01);
        expect_ev(1'b0, 2'b00);
        block_carry = 1'b1;
        len0        = 8'd3;
        req         = 2'b01;
        @(negedge clk);
        en_cyc = 0;
        for (int i = 0; i < 100 && gnt != 2'b00; i++) begin
            @(negedge clk);
            if (cnt_enable) en_cyc++;
        end
        check("wd_run_cycles", en_cyc,     12);
        check("wd_err",        32'(err),   1);
        check("wd_busy",       32'(busy),  0);
        check("wd_no_done",    32'(done),  0);
        block_carry = 1'b0;
        len0        = 8'd0;
        @(negedge clk);
        @(negedge clk);
        check("wd_rerun_done", 32'(done), 32'b01);
        req = 2'b00;
        @(negedge clk);
        check("wd_err_sticky", 32'(err), 1);
`else
        check("no_wd_err", 32'(err), 0);
`endif

        repeat (3) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
